// File: rtl/spi_reg_writer_if.sv
// Host-side handshake and SPI pin bundle for the MFRC-522 register-write engine.
// The master modport belongs to the card-control FSM; the slave modport belongs to the writer.
interface spi_reg_writer_if #(
  parameter int LEN_W = 4
);
  logic             start;
  logic [7:0]       addr;
  logic [LEN_W-1:0] len;
  logic [7:0]       wdata;
  logic             wdata_valid;
  logic             byte_req;
  logic             busy;
  logic             done;
  logic             SCK;
  logic             MOSI;
  logic             SDA;

  modport master (
    output start, addr, len, wdata, wdata_valid,
    input  byte_req, busy, done, SCK, MOSI, SDA
  );

  modport slave (
    input  start, addr, len, wdata, wdata_valid,
    output byte_req, busy, done, SCK, MOSI, SDA
  );
endinterface

// File: rtl/spi_reg_writer.sv
// SPI master that writes an address byte followed by N data bytes to one MFRC-522
// register inside a single chip-select window, two clocks per bit, data fetched per byte.
module spi_reg_writer #(
  parameter int LEN_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  spi_reg_writer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_WAIT,
    S_END,
    S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [7:0]       shift_q, shift_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             sda_q, sda_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             byte_req_q, byte_req_d;

  // Bit 7 clear marks a write; the MFRC-522 only decodes six address bits.
  logic [7:0] abyte;
  assign abyte = {1'b0, bus.addr[5:0], 1'b0};

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    remain_d   = remain_q;
    shift_d    = shift_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    sda_d      = sda_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    byte_req_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shift_d  = abyte;
          mosi_d   = abyte[7];
          remain_d = (bus.len == '0) ? LEN_W'(1) : bus.len;
          sda_d    = 1'b0;
          busy_d   = 1'b1;
          bitcnt_d = 4'd0;
          state_d  = S_HI;
        end
      end
      S_HI: begin
        sck_d    = 1'b1;
        bitcnt_d = bitcnt_q + 4'd1;
        state_d  = S_LO;
      end
      S_LO: begin
        sck_d = 1'b0;
        if (bitcnt_q < 4'd8) begin
          shift_d = {shift_q[6:0], 1'b0};
          mosi_d  = shift_q[6];
          state_d = S_HI;
        end else if (remain_q != '0) begin
          byte_req_d = 1'b1;
          bitcnt_d   = 4'd0;
          state_d    = S_WAIT;
        end else begin
          state_d = S_END;
        end
      end
      S_WAIT: begin
        // MOSI keeps the last bit and SCK stays low for as long as the host stalls.
        sck_d = 1'b0;
        sda_d = 1'b0;
        if (bus.wdata_valid) begin
          shift_d  = bus.wdata;
          mosi_d   = bus.wdata[7];
          remain_d = remain_q - LEN_W'(1);
          state_d  = S_HI;
        end
      end
      S_END: begin
        sda_d   = 1'b1;
        state_d = S_FIN;
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      bitcnt_q   <= 4'd0;
      remain_q   <= '0;
      shift_q    <= 8'd0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      sda_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      byte_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      remain_q   <= remain_d;
      shift_q    <= shift_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      sda_q      <= sda_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      byte_req_q <= byte_req_d;
    end
  end

  assign bus.SCK      = sck_q;
  assign bus.MOSI     = mosi_q;
  assign bus.SDA      = sda_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.byte_req = byte_req_q;

  // The top of the shift register is already mirrored in mosi_q.
  logic unused_bits;
  assign unused_bits = &{bus.addr[7:6], shift_q[7]};
endmodule
